// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: drives a single one-bit ALU slice LSB->MSB, one bit per clock,
// closing the carry loop through a register and assembling result/zero/overflow.
module serial_alu_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             s_a,
    output logic             s_b,
    output logic             s_ainvert,
    output logic             s_binvert,
    output logic             s_less,
    output logic             s_carryin,
    output logic [1:0]       s_operation,
    input  logic             s_result,
    input  logic             s_carryout,
    input  logic             s_set,
    input  logic             s_overflow,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             op_slt;
    logic             op_arith;

    logic             accept;
    logic             last_bit;
    logic             dec_ainv;
    logic             dec_binv;
    logic             dec_cin;
    logic             dec_arith;
    logic             dec_slt;
    logic             dec_ill;
    logic [1:0]       dec_op;
    logic [WIDTH-1:0] res_nxt;

    // Operand bits come straight off shift-register LSBs; less input is never used by this sequencer
    assign s_a    = a_sh[0];
    assign s_b    = b_sh[0];
    assign s_less = 1'b0;

    assign accept   = (state == S_IDLE) && start;
    assign last_bit = (state == S_RUN) && (count == CW'(WIDTH - 1));

    // Control-code decode into slice controls; unsupported codes fall back to AND
    always_comb begin
        dec_ainv  = 1'b0;
        dec_binv  = 1'b0;
        dec_cin   = 1'b0;
        dec_arith = 1'b0;
        dec_slt   = 1'b0;
        dec_ill   = 1'b0;
        dec_op    = 2'b00;
        case (alu_ctl)
            4'b0000: dec_op = 2'b00;
            4'b0001: dec_op = 2'b01;
            4'b0010: begin
                dec_op    = 2'b10;
                dec_arith = 1'b1;
            end
            4'b0110: begin
                dec_op    = 2'b10;
                dec_binv  = 1'b1;
                dec_cin   = 1'b1;
                dec_arith = 1'b1;
            end
            4'b0111: begin
                dec_op   = 2'b11;
                dec_binv = 1'b1;
                dec_cin  = 1'b1;
                dec_slt  = 1'b1;
            end
            4'b1100: begin
                dec_ainv = 1'b1;
                dec_binv = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Result as it will look after this edge; SLT only writes the set bit at the MSB step
    always_comb begin
        res_nxt = result;
        if (!op_slt) begin
            res_nxt[count] = s_result;
        end else if (count == CW'(WIDTH - 1)) begin
            res_nxt = WIDTH'(s_set);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; slice controls are cleared on the MSB step so they read 0 outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            op_slt      <= 1'b0;
            op_arith    <= 1'b0;
            s_ainvert   <= 1'b0;
            s_binvert   <= 1'b0;
            s_operation <= 2'b00;
            s_carryin   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            illegal     <= 1'b0;
            done        <= 1'b0;
            ready       <= 1'b1;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh        <= a_in;
                b_sh        <= b_in;
                op_slt      <= dec_slt;
                op_arith    <= dec_arith;
                s_ainvert   <= dec_ainv;
                s_binvert   <= dec_binv;
                s_operation <= dec_op;
                s_carryin   <= dec_cin;
                illegal     <= dec_ill;
                count       <= '0;
                ready       <= 1'b0;
            end else if (state == S_RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                result <= res_nxt;
                if (last_bit) begin
                    overflow    <= op_arith & s_overflow;
                    zero        <= (res_nxt == '0);
                    done        <= 1'b1;
                    s_ainvert   <= 1'b0;
                    s_binvert   <= 1'b0;
                    s_operation <= 2'b00;
                    s_carryin   <= 1'b0;
                end else begin
                    count     <= count + CW'(1);
                    s_carryin <= s_carryout;
                end
            end else if (state == S_DONE) begin
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Bench for serial_alu_sequencer: a one-bit ALU slice model closes the loop, and results
// are compared against whole-word arithmetic on the operands.
module tb_serial_alu_sequencer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         ready;
    logic [3:0]   alu_ctl;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         s_a, s_b, s_ainvert, s_binvert, s_less, s_carryin;
    logic [1:0]   s_operation;
    logic         s_result, s_carryout, s_set, s_overflow;
    logic [W-1:0] result;
    logic         zero, overflow, illegal, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .alu_ctl(alu_ctl),
        .a_in(a_in), .b_in(b_in), .s_a(s_a), .s_b(s_b), .s_ainvert(s_ainvert),
        .s_binvert(s_binvert), .s_less(s_less), .s_carryin(s_carryin),
        .s_operation(s_operation), .s_result(s_result), .s_carryout(s_carryout),
        .s_set(s_set), .s_overflow(s_overflow), .result(result), .zero(zero),
        .overflow(overflow), .illegal(illegal), .done(done)
    );

    // One-bit ALU slice, combinational
    logic ae, be, sum;
    always_comb begin
        ae         = s_a ^ s_ainvert;
        be         = s_b ^ s_binvert;
        sum        = ae ^ be ^ s_carryin;
        s_carryout = (ae & be) | (ae & s_carryin) | (be & s_carryin);
        s_set      = sum;
        s_overflow = s_carryin ^ s_carryout;
        case (s_operation)
            2'b00:   s_result = ae & be;
            2'b01:   s_result = ae | be;
            2'b10:   s_result = sum;
            default: s_result = s_less;
        endcase
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] r, output logic ov, output logic ill);
        logic [W-1:0] d;
        ov  = 1'b0;
        ill = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                r  = a + b;
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110: begin
                r  = a - b;
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0111: begin
                d = a - b;
                r = W'(d[W-1]);
            end
            4'b1100: r = ~(a | b);
            default: begin
                r   = a & b;
                ill = 1'b1;
            end
        endcase
    endtask

    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input bit inj);
        logic [W-1:0] er;
        logic         eo, ei;
        int           n;
        ref_model(c, a, b, er, eo, ei);
        @(negedge clk);
        chk("ready_pre", W'(ready), W'(1));
        alu_ctl = c;
        a_in    = a;
        b_in    = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        alu_ctl = 4'($urandom);
        a_in    = $urandom;
        b_in    = $urandom;
        chk("ready_busy", W'(ready), W'(0));
        n = 1;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
            start = inj && (n == 5);
        end
        start = 1'b0;
        chk("latency", W'(n), W'(W + 1));
        chk("result", result, er);
        chk("zero", W'(zero), W'(er == '0));
        chk("overflow", W'(overflow), W'(eo));
        chk("illegal", W'(illegal), W'(ei));
        @(negedge clk);
        chk("done_pulse", W'(done), W'(0));
        chk("ready_post", W'(ready), W'(1));
        chk("slice_idle", W'({s_ainvert, s_binvert, s_operation, s_carryin, s_a, s_b}), W'(0));
        chk("result_hold", result, er);
    endtask

    logic [3:0] codes [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};

    initial begin
        int seen;
        logic [W-1:0] ra, rb;
        rst_n   = 1'b0;
        start   = 1'b0;
        alu_ctl = 4'b0000;
        a_in    = '0;
        b_in    = '0;
        #22;
        chk("rst_ready", W'(ready), W'(1));
        chk("rst_outs", W'({zero, overflow, illegal, done}), W'(0));
        chk("rst_result", result, '0);
        chk("rst_slice", W'({s_ainvert, s_binvert, s_operation, s_carryin, s_a, s_b, s_less}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(4'b0110, 32'h0000_0005, 32'h0000_0005, 1'b0);
        run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 1'b0);
        run_op(4'b0111, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        run_op(4'b0111, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0);
        run_op(4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0);
        run_op(4'b0010, 32'h1234_5678, 32'h0101_0101, 1'b1);
        run_op(4'b1010, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0);
        run_op(4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
        run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);

        // Abandon an op mid-flight with reset at count=10
        @(negedge clk);
        alu_ctl = 4'b0010;
        a_in    = 32'h0000_00FF;
        b_in    = 32'h0000_0001;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", W'(ready), W'(1));
        chk("midrst_result", result, '0);
        chk("midrst_done", W'(done), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", W'(seen), W'(0));
        chk("midrst_idle", W'(ready), W'(1));
        run_op(4'b0110, 32'h0000_0010, 32'h0000_0020, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_op(codes[$urandom_range(0, 6)], ra, rb, (i == 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
